uart_cmd_rx: RTL and testbench

//   Host-to-scope command path: UART receiver plus frame parser for configuration

---
 rtl/uart_cmd_rx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver plus 4-byte frame parser (0x55, addr, data, sum)
//   that writes the scope control registers.
// Latency: cfg_update / cmd_err arrive 2 cycles after the SUM stop-bit sample.
// Backpressure: none; the serial line cannot be stalled, so every byte is consumed.
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   uart_rx                 serial input, idle high, 8N1 (8E1 with UART_PARITY_EN)
//   trig_level, chan_sel,
//   adc_div, run            control registers
//   cfg_update              1-cycle pulse, a register was written
//   frame_err               1-cycle pulse, bad stop (or parity) bit
//   cmd_err                 1-cycle pulse, bad checksum or unknown address
// Build option: define UART_PARITY_EN to expect an even-parity bit before STOP.
module uart_cmd_rx #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter logic [7:0]  TRIG_DEFAULT = 8'd100
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       uart_rx,
  output logic [7:0] trig_level,
  output logic [1:0] chan_sel,
  output logic [7:0] adc_div,
  output logic       run,
  output logic       cfg_update,
  output logic       frame_err,
  output logic       cmd_err
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam int unsigned CW       = $clog2(BAUD_DIV + 1);

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
`ifdef UART_PARITY_EN
    B_PARITY,
`endif
    B_STOP,
    B_BRK       // bad stop bit seen: wait for the line to return high
  } bit_state_t;

  typedef enum logic [1:0] {P_HDR, P_ADDR, P_DATA, P_SUM} parse_state_t;

  // ---------------- input synchroniser ----------------
  logic rx_s1, rx_sync, rx_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
    end
  end

  // ---------------- bit receiver ----------------
  bit_state_t    b_state, b_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick, par_ok;
  logic          byte_vld, byte_vld_nxt, ferr_nxt;

  // START waits half a bit to land mid-bit; later states wait a full bit.
  assign tick = (b_state == B_START) ? (cnt == CW'(HALF - 1))
                                     : (cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) b_state <= B_IDLE;
    else          b_state <= b_nxt;
  end

  always_comb begin
    b_nxt        = b_state;
    byte_vld_nxt = 1'b0;
    ferr_nxt     = 1'b0;
    case (b_state)
      B_IDLE:  if (rx_prev && !rx_sync) b_nxt = B_START;
      B_START: if (tick) b_nxt = rx_sync ? B_IDLE : B_DATA;   // high = glitch
      B_DATA: begin
        if (tick && bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          b_nxt = B_PARITY;
`else
          b_nxt = B_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      B_PARITY: if (tick) b_nxt = B_STOP;
`endif
      B_STOP: begin
        if (tick) begin
          if (rx_sync && par_ok) begin
            byte_vld_nxt = 1'b1;
            b_nxt        = B_IDLE;
          end else begin
            ferr_nxt = 1'b1;
            b_nxt    = rx_sync ? B_IDLE : B_BRK;
          end
        end
      end
      B_BRK:   if (rx_sync) b_nxt = B_IDLE;
      default: b_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (b_state == B_IDLE || b_state == B_BRK || tick) cnt <= '0;
      else                                                cnt <= cnt + CW'(1);
      if (b_state == B_START)              bit_idx <= '0;
      else if (b_state == B_DATA && tick)  bit_idx <= bit_idx + 3'd1;
      if (b_state == B_DATA && tick)       shreg <= {rx_sync, shreg[7:1]};
      byte_vld  <= byte_vld_nxt;
      frame_err <= ferr_nxt;
    end
  end

`ifdef UART_PARITY_EN
  // Even parity: the parity bit equals the XOR of the data bits.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                          par_ok <= 1'b1;
    else if (b_state == B_PARITY && tick)  par_ok <= (rx_sync == ^shreg);
  end
`else
  assign par_ok = 1'b1;
`endif

  // ---------------- frame parser ----------------
  parse_state_t p_state, p_nxt;
  logic [7:0]   addr_q, data_q, sum;
  logic         wr, cerr;

  assign sum = addr_q + data_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) p_state <= P_HDR;
    else          p_state <= p_nxt;
  end

  always_comb begin
    p_nxt = p_state;
    wr    = 1'b0;
    cerr  = 1'b0;
    if (frame_err) begin
      p_nxt = P_HDR;
    end else if (byte_vld) begin
      case (p_state)
        P_HDR:  if (shreg == 8'h55) p_nxt = P_ADDR;
        P_ADDR: p_nxt = P_DATA;
        P_DATA: p_nxt = P_SUM;
        default: begin
          p_nxt = P_HDR;
          if (shreg == sum && addr_q >= 8'h01 && addr_q <= 8'h04) wr   = 1'b1;
          else                                                    cerr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q     <= '0;
      data_q     <= '0;
      trig_level <= TRIG_DEFAULT;
      chan_sel   <= '0;
      adc_div    <= 8'd1;
      run        <= 1'b0;
      cfg_update <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      if (byte_vld && p_state == P_ADDR) addr_q <= shreg;
      if (byte_vld && p_state == P_DATA) data_q <= shreg;
      cfg_update <= wr;
      cmd_err    <= cerr;
      if (wr) begin
        case (addr_q)
          8'h01:   trig_level <= data_q;
          8'h02:   chan_sel   <= data_q[1:0];
          8'h03:   adc_div    <= (data_q == 8'd0) ? 8'd1 : data_q;  // divider of 0 would stall ADC_Clk
          8'h04:   run        <= data_q[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx. A faster baud rate (64 clocks per bit) keeps
// the run short; glitch length is scaled to stay below half a bit.
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 781_250;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] trig_level;
  logic [1:0] chan_sel;
  logic [7:0] adc_div;
  logic       run, cfg_update, frame_err, cmd_err;

  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TRIG_DEFAULT(8'd100)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .uart_rx(uart_rx),
    .trig_level(trig_level), .chan_sel(chan_sel), .adc_div(adc_div), .run(run),
    .cfg_update(cfg_update), .frame_err(frame_err), .cmd_err(cmd_err)
  );

  always #5 Clk = ~Clk;

  int cyc, n_cfg, n_ferr, n_cerr, n_both, cfg_cyc;
  int stop_cyc;
  int errors, checks;
  int c0, f0, e0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Pulse counters, sampled away from the active edge.
  always @(negedge Clk) begin
    if (cfg_update) begin
      n_cfg   <= n_cfg + 1;
      cfg_cyc <= cyc;
    end
    if (frame_err)            n_ferr <= n_ferr + 1;
    if (cmd_err)              n_cerr <= n_cerr + 1;
    if (cfg_update && cmd_err) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge Clk);
    end
`ifdef UART_PARITY_EN
    uart_rx = ^b;
    repeat (BIT) @(negedge Clk);
`endif
    stop_cyc = cyc;
    uart_rx  = stop;
    repeat (BIT) @(negedge Clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] s);
    send_byte(8'h55, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d, 1'b1);
    send_byte(s, 1'b1);
    repeat (4) @(negedge Clk);
  endtask

  task automatic snap();
    c0 = n_cfg;
    f0 = n_ferr;
    e0 = n_cerr;
  endtask

  initial begin
    int lat;
    // ---- reset state ----
    repeat (5) @(negedge Clk);
    check("rst_trig", trig_level, 100);
    check("rst_chan", chan_sel, 0);
    check("rst_div", adc_div, 1);
    check("rst_run", run, 0);
    check("rst_cfg", cfg_update, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_cerr", cmd_err, 0);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);

    // ---- 1: trig_level write ----
    snap();
    send_frame(8'h01, 8'h96, 8'h97);
    check("t1_trig", trig_level, 8'h96);
    check("t1_cfg_pulses", n_cfg - c0, 1);
    check("t1_cmd_err", n_cerr - e0, 0);
    lat = cfg_cyc - stop_cyc;
    check("t1_latency_in_window", int'(lat >= HALF && lat <= HALF + 8), 1);

    // ---- 2: adc_div write, then 0 clamps to 1 ----
    snap();
    send_frame(8'h03, 8'h07, 8'h0A);
    check("t2_div7", adc_div, 7);
    send_frame(8'h03, 8'h00, 8'h03);
    check("t2_div0_is_1", adc_div, 1);
    check("t2_cfg_pulses", n_cfg - c0, 2);

    // ---- 3: bad checksum, then unknown address ----
    snap();
    send_frame(8'h02, 8'h03, 8'h06);
    check("t3_cmd_err", n_cerr - e0, 1);
    check("t3_chan", chan_sel, 0);
    send_frame(8'h07, 8'h01, 8'h08);
    check("t3_badaddr_cmd_err", n_cerr - e0, 2);
    check("t3_no_cfg", n_cfg - c0, 0);
    check("t3_trig_kept", trig_level, 8'h96);

    // ---- 4: stop bit 0, then good run frame ----
    snap();
    send_byte(8'hA5, 1'b0);
    repeat (2 * BIT) @(negedge Clk);
    check("t4_frame_err", n_ferr - f0, 1);
    check("t4_no_cfg_yet", n_cfg - c0, 0);
    send_frame(8'h04, 8'h01, 8'h05);
    check("t4_run", run, 1);
    check("t4_cfg", n_cfg - c0, 1);

    // ---- 5: short low glitch on idle line ----
    snap();
    uart_rx = 1'b0;
    repeat (HALF - 8) @(negedge Clk);
    uart_rx = 1'b1;
    repeat (2 * BIT) @(negedge Clk);
    check("t5_ferr", n_ferr - f0, 0);
    check("t5_cerr", n_cerr - e0, 0);
    check("t5_cfg", n_cfg - c0, 0);
    check("t5_trig", trig_level, 8'h96);
    check("t5_run", run, 1);

    // ---- 6: reset during the data byte of 55 01 20 21 ----
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    uart_rx = 1'b0;                       // start bit + data bits 0..3 of 0x20
    repeat (5 * BIT) @(negedge Clk);
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("t6_trig_in_reset", trig_level, 100);
    check("t6_run_in_reset", run, 0);
    Reset_n = 1'b1;
    snap();
    repeat (BIT - 3) @(negedge Clk);      // rest of bit 4 (0)
    uart_rx = 1'b1; repeat (BIT) @(negedge Clk);   // bit 5
    uart_rx = 1'b0; repeat (2 * BIT) @(negedge Clk); // bits 6,7
    uart_rx = 1'b1; repeat (BIT) @(negedge Clk);   // stop
    send_byte(8'h21, 1'b1);
    repeat (12 * BIT) @(negedge Clk);
    check("t6_trig_after", trig_level, 100);
    check("t6_no_cfg", n_cfg - c0, 0);
    send_frame(8'h02, 8'h03, 8'h05);
    check("t6_recover_chan", chan_sel, 3);
    check("t6_recover_cfg", n_cfg - c0, 1);

    check("never_both", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
